// File: rtl/bus_invert_encoder.sv
// Bus-invert encoder with a one-word valid/ready output register.
// Each accepted word is sent either true or inverted, whichever changes
// fewer bus lines relative to the word currently held on bus_out. Two
// saturating counters report the line toggles an unencoded bus would
// have made and the toggles actually made on bus_out plus invert.
// WIDTH is expected to be even and at least 2.
module bus_invert_encoder #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] bus_out,
  output logic             invert,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             stats_clr,
  output logic [CNT_W-1:0] raw_toggles,
  output logic [CNT_W-1:0] enc_toggles
);

  // Popcount width must hold WIDTH+1 (data bits plus the invert line).
  localparam int HW    = $clog2(WIDTH + 2);
  // Counter sum is one bit wider than its widest operand, so it cannot
  // overflow before the saturation check.
  localparam int SUM_W = ((CNT_W > HW) ? CNT_W : HW) + 1;

  localparam logic [HW-1:0]    HALF    = HW'(WIDTH / 2);
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

  logic [WIDTH-1:0] busOut_q, busOut_d;
  logic             invert_q, invert_d;
  logic             outValid_q, outValid_d;
  logic [WIDTH-1:0] prevRaw_q, prevRaw_d;
  logic [CNT_W-1:0] rawToggles_q, rawToggles_d;
  logic [CNT_W-1:0] encToggles_q, encToggles_d;

  logic             accept;
  logic [HW-1:0]    hamming;
  logic             newInvert;
  logic [HW-1:0]    rawInc;
  logic [HW-1:0]    encInc;
  logic [SUM_W-1:0] rawSum;
  logic [SUM_W-1:0] encSum;

  function automatic logic [HW-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [HW-1:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) begin
      c = c + HW'(v[i]);
    end
    return c;
  endfunction

  // The output register can take a word when empty or being drained.
  assign in_ready    = !outValid_q || out_ready;
  assign bus_out     = busOut_q;
  assign invert      = invert_q;
  assign out_valid   = outValid_q;
  assign raw_toggles = rawToggles_q;
  assign enc_toggles = encToggles_q;

  // Bus path: invert decision against the held word, load or drain.
  always_comb begin
    busOut_d   = busOut_q;
    invert_d   = invert_q;
    outValid_d = outValid_q;
    prevRaw_d  = prevRaw_q;
    accept     = in_valid && in_ready;
    hamming    = popcount(data_in ^ busOut_q);
    if (hamming > HALF) begin
      newInvert = 1'b1;
    end else if (hamming < HALF) begin
      newInvert = 1'b0;
    end else begin
      newInvert = invert_q;
    end
    if (accept) begin
      busOut_d   = newInvert ? ~data_in : data_in;
      invert_d   = newInvert;
      outValid_d = 1'b1;
      prevRaw_d  = data_in;
    end else if (out_ready) begin
      outValid_d = 1'b0;
    end
  end

  // Statistics: clear wins over any increment, sums saturate at all-ones.
  always_comb begin
    rawToggles_d = rawToggles_q;
    encToggles_d = encToggles_q;
    rawInc       = popcount(data_in ^ prevRaw_q);
    encInc       = popcount(busOut_d ^ busOut_q) + HW'(invert_d != invert_q);
    rawSum       = SUM_W'(rawToggles_q) + SUM_W'(rawInc);
    encSum       = SUM_W'(encToggles_q) + SUM_W'(encInc);
    if (stats_clr) begin
      rawToggles_d = '0;
      encToggles_d = '0;
    end else if (accept) begin
      rawToggles_d = (rawSum > CNT_MAX) ? {CNT_W{1'b1}} : rawSum[CNT_W-1:0];
      encToggles_d = (encSum > CNT_MAX) ? {CNT_W{1'b1}} : encSum[CNT_W-1:0];
    end
  end

  // State registers; reset clears everything, dropping any held word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busOut_q     <= '0;
      invert_q     <= 1'b0;
      outValid_q   <= 1'b0;
      prevRaw_q    <= '0;
      rawToggles_q <= '0;
      encToggles_q <= '0;
    end else begin
      busOut_q     <= busOut_d;
      invert_q     <= invert_d;
      outValid_q   <= outValid_d;
      prevRaw_q    <= prevRaw_d;
      rawToggles_q <= rawToggles_d;
      encToggles_q <= encToggles_d;
    end
  end

endmodule

// File: tb/tb_bus_invert_encoder.sv
// Directed testbench for bus_invert_encoder (WIDTH=8, CNT_W=16).
module tb_bus_invert_encoder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  data_in;
  logic [7:0]  bus_out;
  logic        invert;
  logic        out_valid;
  logic        out_ready;
  logic        stats_clr;
  logic [15:0] raw_toggles;
  logic [15:0] enc_toggles;

  int testsRun;
  int testsFailed;

  bus_invert_encoder #(.WIDTH(8), .CNT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .data_in    (data_in),
    .bus_out    (bus_out),
    .invert     (invert),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .stats_clr  (stats_clr),
    .raw_toggles(raw_toggles),
    .enc_toggles(enc_toggles)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one word with the consumer ready and clock it in.
  task automatic send(input logic [7:0] d);
    in_valid  = 1'b1;
    data_in   = d;
    out_ready = 1'b1;
    step();
  endtask

  // Hold reset for two cycles, release it away from the clock edge.
  task automatic do_reset();
    in_valid  = 1'b0;
    data_in   = 8'h00;
    out_ready = 1'b0;
    stats_clr = 1'b0;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
  endtask

  // Reset state: everything zero, in_ready high.
  task automatic test_reset();
    in_valid  = 1'b0;
    data_in   = 8'h00;
    out_ready = 1'b0;
    stats_clr = 1'b0;
    rst_n     = 1'b0;
    #12;
    testsRun++;
    if ({bus_out, invert, out_valid, in_ready} !== {8'h00, 1'b0, 1'b0, 1'b1}) begin
      testsFailed++;
      $display("[TB] FAIL reset_outputs: got bus=%h inv=%b vld=%b rdy=%b expected bus=00 inv=0 vld=0 rdy=1",
               bus_out, invert, out_valid, in_ready);
    end
    testsRun++;
    if ({raw_toggles, enc_toggles} !== 32'h0) begin
      testsFailed++;
      $display("[TB] FAIL reset_counters: got raw=%0d enc=%0d expected 0 0", raw_toggles, enc_toggles);
    end
    do_reset();
  endtask

  // Full invert, then a tie that keeps invert, then drain with baseline held.
  task automatic test_tie();
    do_reset();
    send(8'hFF);
    testsRun++;
    if ({bus_out, invert, out_valid, raw_toggles, enc_toggles} !== {8'h00, 1'b1, 1'b1, 16'd8, 16'd1}) begin
      testsFailed++;
      $display("[TB] FAIL send_ff: got bus=%h inv=%b vld=%b raw=%0d enc=%0d expected 00 1 1 8 1",
               bus_out, invert, out_valid, raw_toggles, enc_toggles);
    end
    send(8'h0F);
    testsRun++;
    if ({bus_out, invert, out_valid, raw_toggles, enc_toggles} !== {8'hF0, 1'b1, 1'b1, 16'd12, 16'd5}) begin
      testsFailed++;
      $display("[TB] FAIL tie_keeps_invert: got bus=%h inv=%b vld=%b raw=%0d enc=%0d expected f0 1 1 12 5",
               bus_out, invert, out_valid, raw_toggles, enc_toggles);
    end
    in_valid = 1'b0;
    step();
    testsRun++;
    if ({bus_out, invert, out_valid, raw_toggles, enc_toggles} !== {8'hF0, 1'b1, 1'b0, 16'd12, 16'd5}) begin
      testsFailed++;
      $display("[TB] FAIL drain_holds_bus: got bus=%h inv=%b vld=%b raw=%0d enc=%0d expected f0 1 0 12 5",
               bus_out, invert, out_valid, raw_toggles, enc_toggles);
    end
  endtask

  // Below-half keeps true polarity, above-half flips, idle keeps baseline.
  task automatic test_invert();
    do_reset();
    send(8'h03);
    testsRun++;
    if ({bus_out, invert, raw_toggles, enc_toggles} !== {8'h03, 1'b0, 16'd2, 16'd2}) begin
      testsFailed++;
      $display("[TB] FAIL send_03: got bus=%h inv=%b raw=%0d enc=%0d expected 03 0 2 2",
               bus_out, invert, raw_toggles, enc_toggles);
    end
    send(8'hFC);
    testsRun++;
    if ({bus_out, invert, raw_toggles, enc_toggles} !== {8'h03, 1'b1, 16'd10, 16'd3}) begin
      testsFailed++;
      $display("[TB] FAIL send_fc: got bus=%h inv=%b raw=%0d enc=%0d expected 03 1 10 3",
               bus_out, invert, raw_toggles, enc_toggles);
    end
    in_valid = 1'b0;
    step();
    testsRun++;
    if ({bus_out, invert, out_valid} !== {8'h03, 1'b1, 1'b0}) begin
      testsFailed++;
      $display("[TB] FAIL idle_baseline: got bus=%h inv=%b vld=%b expected 03 1 0",
               bus_out, invert, out_valid);
    end
    send(8'h03);
    testsRun++;
    if ({bus_out, invert, out_valid, raw_toggles, enc_toggles} !== {8'h03, 1'b0, 1'b1, 16'd18, 16'd4}) begin
      testsFailed++;
      $display("[TB] FAIL resend_after_idle: got bus=%h inv=%b vld=%b raw=%0d enc=%0d expected 03 0 1 18 4",
               bus_out, invert, out_valid, raw_toggles, enc_toggles);
    end
  endtask

  // Stall for five cycles, then consume and accept together.
  task automatic test_stall();
    int stallBad;
    stallBad  = 0;
    in_valid  = 1'b1;
    data_in   = 8'hAA;
    out_ready = 1'b0;
    #1;
    testsRun++;
    if (in_ready !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL stall_ready_comb: got rdy=%b expected 0", in_ready);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      if ({bus_out, invert, out_valid, in_ready, raw_toggles, enc_toggles} !==
          {8'h03, 1'b0, 1'b1, 1'b0, 16'd18, 16'd4}) begin
        stallBad++;
      end
    end
    testsRun++;
    if (stallBad != 0) begin
      testsFailed++;
      $display("[TB] FAIL stall_stable: got %0d unstable cycles expected 0 (last bus=%h inv=%b vld=%b rdy=%b)",
               stallBad, bus_out, invert, out_valid, in_ready);
    end
    out_ready = 1'b1;
    #1;
    testsRun++;
    if (in_ready !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL release_ready: got rdy=%b expected 1", in_ready);
    end
    step();
    testsRun++;
    if ({bus_out, invert, out_valid, raw_toggles, enc_toggles} !== {8'hAA, 1'b0, 1'b1, 16'd22, 16'd8}) begin
      testsFailed++;
      $display("[TB] FAIL stall_release_accept: got bus=%h inv=%b vld=%b raw=%0d enc=%0d expected aa 0 1 22 8",
               bus_out, invert, out_valid, raw_toggles, enc_toggles);
    end
  endtask

  // Consecutive accepts with no bubble between them.
  task automatic test_back_to_back();
    send(8'h55);
    testsRun++;
    if ({bus_out, invert, out_valid, raw_toggles, enc_toggles} !== {8'hAA, 1'b1, 1'b1, 16'd30, 16'd9}) begin
      testsFailed++;
      $display("[TB] FAIL back_to_back: got bus=%h inv=%b vld=%b raw=%0d enc=%0d expected aa 1 1 30 9",
               bus_out, invert, out_valid, raw_toggles, enc_toggles);
    end
  endtask

  // Drive raw_toggles into saturation, then clear alongside an accept.
  task automatic test_saturation();
    do_reset();
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 8200; i++) begin
      data_in = (i % 2 == 0) ? 8'hFF : 8'h00;
      step();
      if (i == 8190) begin
        testsRun++;
        if (raw_toggles !== 16'd65528) begin
          testsFailed++;
          $display("[TB] FAIL pre_saturation: got raw=%0d expected 65528", raw_toggles);
        end
      end
    end
    testsRun++;
    if ({raw_toggles, enc_toggles} !== {16'hFFFF, 16'd8200}) begin
      testsFailed++;
      $display("[TB] FAIL saturation: got raw=%0d enc=%0d expected 65535 8200", raw_toggles, enc_toggles);
    end
    stats_clr = 1'b1;
    data_in   = 8'hFF;
    step();
    stats_clr = 1'b0;
    testsRun++;
    if ({bus_out, invert, out_valid, raw_toggles, enc_toggles} !== {8'h00, 1'b1, 1'b1, 16'd0, 16'd0}) begin
      testsFailed++;
      $display("[TB] FAIL clear_with_accept: got bus=%h inv=%b vld=%b raw=%0d enc=%0d expected 00 1 1 0 0",
               bus_out, invert, out_valid, raw_toggles, enc_toggles);
    end
    send(8'h00);
    testsRun++;
    if ({raw_toggles, enc_toggles} !== {16'd8, 16'd1}) begin
      testsFailed++;
      $display("[TB] FAIL count_after_clear: got raw=%0d enc=%0d expected 8 1", raw_toggles, enc_toggles);
    end
  endtask

  // Asynchronous reset between edges drops a stalled word immediately.
  task automatic test_async_reset();
    send(8'h5A);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    data_in   = 8'h33;
    step();
    testsRun++;
    if ({out_valid, in_ready} !== {1'b1, 1'b0}) begin
      testsFailed++;
      $display("[TB] FAIL pre_reset_stall: got vld=%b rdy=%b expected 1 0", out_valid, in_ready);
    end
    #2;
    rst_n = 1'b0;
    #1;
    testsRun++;
    if ({bus_out, invert, out_valid, in_ready, raw_toggles, enc_toggles} !==
        {8'h00, 1'b0, 1'b0, 1'b1, 16'd0, 16'd0}) begin
      testsFailed++;
      $display("[TB] FAIL async_reset: got bus=%h inv=%b vld=%b rdy=%b raw=%0d enc=%0d expected 00 0 0 1 0 0",
               bus_out, invert, out_valid, in_ready, raw_toggles, enc_toggles);
    end
    in_valid = 1'b0;
    #2;
    rst_n = 1'b1;
    step();
    testsRun++;
    if ({bus_out, out_valid} !== {8'h00, 1'b0}) begin
      testsFailed++;
      $display("[TB] FAIL post_reset_idle: got bus=%h vld=%b expected 00 0", bus_out, out_valid);
    end
  endtask

  // Run all scenarios in order and report.
  initial begin
    testsRun    = 0;
    testsFailed = 0;
    test_reset();
    test_tie();
    test_invert();
    test_stall();
    test_back_to_back();
    test_saturation();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
